// File: rtl/wb_retire_queue.sv
// ---------------------------------------------------------------------------
// wb_retire_queue
//
// Purpose: in-order write-back retire queue. Each issuing instruction with a
// non-zero destination register gets a slot. The slot is addressed directly
// by its tag. Execution units complete slots in any order. Slots retire
// strictly in tag order, at most one per cycle, onto registered write-back
// outputs.
//
// Handshake: an issue is accepted on a rising edge where IssueValid and
// IssueReady are both high. IssueReady depends only on the registered slot
// count, so a retire in the same cycle does not free a credit early.
// Completion has no ready signal: every CplValid cycle is consumed, either
// as a legal result or as a sticky error.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   IssueValid/IssueRd  issuing instruction and its destination register
//   IssueReady          a slot is free
//   IssueTag            tag the current issue receives (HorizonTag + 1)
//   CplValid/CplTag/    result returning from an execution unit
//   CplData
//   WbAddr/WbTag/RdData registered retire outputs; WbAddr == 0 means no retire
//   Occupancy           number of allocated slots
//   CplErr              sticky: completion to a free or already-done slot
// ---------------------------------------------------------------------------
module wb_retire_queue #(
    parameter bit embedded = 1'b1,
    parameter int wb_depth = 16,
    localparam int raddr_w = embedded ? 4 : 5,
    localparam int tag_w   = (wb_depth > 1) ? $clog2(wb_depth) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               IssueValid,
    input  logic [raddr_w-1:0] IssueRd,
    output logic               IssueReady,
    output logic [tag_w-1:0]   IssueTag,
    input  logic               CplValid,
    input  logic [tag_w-1:0]   CplTag,
    input  logic [31:0]        CplData,
    output logic [raddr_w-1:0] WbAddr,
    output logic [tag_w-1:0]   WbTag,
    output logic [31:0]        RdData,
    output logic [tag_w:0]     Occupancy,
    output logic               CplErr
);

    // Arrays cover the full tag space so every tag value indexes a real slot.
    localparam int Slots = 1 << tag_w;
    localparam logic [tag_w:0] DepthCnt = (tag_w+1)'(wb_depth);

    logic [raddr_w-1:0] slotRd   [Slots];
    logic [31:0]        slotData [Slots];
    logic [Slots-1:0]   slotAlloc;
    logic [Slots-1:0]   slotDone;

    logic [tag_w-1:0] headTag;
    logic [tag_w-1:0] tailTag;
    logic [tag_w-1:0] horizonTag;
    logic [tag_w:0]   count;

    logic issueAcc;
    logic doAlloc;
    logic cplOk;
    logic cplBad;
    logic doRetire;

    always_comb begin
        issueAcc = IssueValid & IssueReady;
        // rd == 0 writes nothing back, so it takes no slot and no tag.
        doAlloc  = issueAcc & (IssueRd != '0);
        cplOk    = CplValid & slotAlloc[CplTag] & ~slotDone[CplTag];
        cplBad   = CplValid & ~cplOk;
        // Uses registered done only: a completion to the head becomes
        // retireable one cycle later, never in the same cycle.
        doRetire = slotAlloc[headTag] & slotDone[headTag];
    end

    assign IssueReady = (count < DepthCnt);
    assign IssueTag   = horizonTag + tag_w'(1);
    assign Occupancy  = count;

    // Control state, pointers and registered outputs.
    // A retiring head never collides with the tail being allocated: they
    // coincide only when count is 0 (no retire) or full (no issue).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotAlloc  <= '0;
            slotDone   <= '0;
            headTag    <= tag_w'(1);
            tailTag    <= tag_w'(1);
            horizonTag <= '0;
            count      <= '0;
            WbAddr     <= '0;
            WbTag      <= '0;
            RdData     <= '0;
            CplErr     <= 1'b0;
        end else begin
            if (doRetire) begin
                slotAlloc[headTag] <= 1'b0;
                slotDone[headTag]  <= 1'b0;
                headTag            <= headTag + tag_w'(1);
                WbAddr             <= slotRd[headTag];
                WbTag              <= headTag;
                RdData             <= slotData[headTag];
            end else begin
                WbAddr <= '0;
            end

            if (doAlloc) begin
                slotAlloc[tailTag] <= 1'b1;
                slotDone[tailTag]  <= 1'b0;
                tailTag            <= tailTag + tag_w'(1);
                horizonTag         <= horizonTag + tag_w'(1);
            end

            if (cplOk) begin
                slotDone[CplTag] <= 1'b1;
            end

            if (cplBad) begin
                CplErr <= 1'b1;
            end

            case ({doAlloc, doRetire})
                2'b10:   count <= count + (tag_w+1)'(1);
                2'b01:   count <= count - (tag_w+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot payload needs no reset: it is only read while the slot is
    // allocated and done, and both are written before that can happen.
    always_ff @(posedge clk) begin
        if (doAlloc) begin
            slotRd[tailTag] <= IssueRd;
        end
        if (cplOk) begin
            slotData[CplTag] <= CplData;
        end
    end

endmodule

// File: tb/tb_wb_retire_queue.sv
module tb_wb_retire_queue;

    localparam int RaddrW = 4;
    localparam int TagW   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              IssueValid;
    logic [RaddrW-1:0] IssueRd;
    logic              IssueReady;
    logic [TagW-1:0]   IssueTag;
    logic              CplValid;
    logic [TagW-1:0]   CplTag;
    logic [31:0]       CplData;
    logic [RaddrW-1:0] WbAddr;
    logic [TagW-1:0]   WbTag;
    logic [31:0]       RdData;
    logic [TagW:0]     Occupancy;
    logic              CplErr;

    wb_retire_queue #(.embedded(1'b1), .wb_depth(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .IssueValid (IssueValid),
        .IssueRd    (IssueRd),
        .IssueReady (IssueReady),
        .IssueTag   (IssueTag),
        .CplValid   (CplValid),
        .CplTag     (CplTag),
        .CplData    (CplData),
        .WbAddr     (WbAddr),
        .WbTag      (WbTag),
        .RdData     (RdData),
        .Occupancy  (Occupancy),
        .CplErr     (CplErr)
    );

    int nVec = 0;
    int nErr = 0;
    int retired = 0;

    // scoreboard entries: {rd, tag}
    logic [RaddrW+TagW-1:0] exp_q[$];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        IssueValid = 1'b0;
        IssueRd    = '0;
        CplValid   = 1'b0;
        CplTag     = '0;
        CplData    = '0;
        rst_n      = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [RaddrW-1:0] rd, input logic [TagW-1:0] expTag);
        IssueValid = 1'b1;
        IssueRd    = rd;
        check("issue_tag", 32'(IssueTag), 32'(expTag));
        step();
        IssueValid = 1'b0;
    endtask

    task automatic complete(input logic [TagW-1:0] tag, input logic [31:0] data);
        CplValid = 1'b1;
        CplTag   = tag;
        CplData  = data;
        step();
        CplValid = 1'b0;
    endtask

    task automatic sbSample();
        logic [RaddrW+TagW-1:0] e;
        if (WbAddr != '0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_retire", 32'(WbAddr), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_wb_addr", 32'(WbAddr), 32'(e[RaddrW+TagW-1:TagW]));
                check("sb_wb_tag", 32'(WbTag), 32'(e[TagW-1:0]));
                check("sb_rd_data", RdData, 32'hC0DE_0000 | 32'(e[TagW-1:0]));
                retired++;
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state and single issue/complete/retire
        doReset();
        check("rst_wb_addr", 32'(WbAddr), 32'd0);
        check("rst_wb_tag", 32'(WbTag), 32'd0);
        check("rst_rd_data", RdData, 32'd0);
        check("rst_occ", 32'(Occupancy), 32'd0);
        check("rst_cpl_err", 32'(CplErr), 32'd0);
        check("rst_ready", 32'(IssueReady), 32'd1);
        check("rst_issue_tag", 32'(IssueTag), 32'd1);

        issue(4'd3, 4'd1);
        check("single_occ", 32'(Occupancy), 32'd1);
        complete(4'd1, 32'hDEAD_BEEF);
        check("single_no_bypass", 32'(WbAddr), 32'd0);
        step();
        check("single_wb_addr", 32'(WbAddr), 32'd3);
        check("single_wb_tag", 32'(WbTag), 32'd1);
        check("single_rd_data", RdData, 32'hDEAD_BEEF);
        check("single_occ_after", 32'(Occupancy), 32'd0);
        step();
        check("single_wb_idle", 32'(WbAddr), 32'd0);
        check("single_tag_hold", 32'(WbTag), 32'd1);
        check("single_data_hold", RdData, 32'hDEAD_BEEF);

        // Out-of-order completion, in-order retire
        doReset();
        issue(4'd1, 4'd1);
        issue(4'd2, 4'd2);
        issue(4'd3, 4'd3);
        check("ooo_occ", 32'(Occupancy), 32'd3);
        complete(4'd3, 32'h0000_0103);
        check("ooo_wait3", 32'(WbAddr), 32'd0);
        complete(4'd2, 32'h0000_0102);
        check("ooo_wait2", 32'(WbAddr), 32'd0);
        complete(4'd1, 32'h0000_0101);
        check("ooo_wait1", 32'(WbAddr), 32'd0);
        step();
        check("ooo_r1_addr", 32'(WbAddr), 32'd1);
        check("ooo_r1_data", RdData, 32'h0000_0101);
        step();
        check("ooo_r2_addr", 32'(WbAddr), 32'd2);
        check("ooo_r2_tag", 32'(WbTag), 32'd2);
        step();
        check("ooo_r3_addr", 32'(WbAddr), 32'd3);
        check("ooo_r3_data", RdData, 32'h0000_0103);
        step();
        check("ooo_idle", 32'(WbAddr), 32'd0);
        check("ooo_occ_end", 32'(Occupancy), 32'd0);

        // Full queue
        doReset();
        for (int i = 0; i < 16; i++) begin
            issue(4'((i % 15) + 1), 4'((i + 1) % 16));
        end
        check("full_ready", 32'(IssueReady), 32'd0);
        check("full_occ", 32'(Occupancy), 32'd16);
        IssueValid = 1'b1;
        IssueRd    = 4'd5;
        check("full_issue_tag", 32'(IssueTag), 32'd1);
        step();
        IssueValid = 1'b0;
        check("full_ignored_occ", 32'(Occupancy), 32'd16);
        check("full_ignored_ready", 32'(IssueReady), 32'd0);
        complete(4'd1, 32'h0000_0055);
        check("full_ready_before_retire", 32'(IssueReady), 32'd0);
        step();
        check("full_retire_addr", 32'(WbAddr), 32'd1);
        check("full_retire_data", RdData, 32'h0000_0055);
        check("full_occ_after", 32'(Occupancy), 32'd15);
        check("full_ready_after", 32'(IssueReady), 32'd1);

        // rd == 0 issue and illegal completion
        doReset();
        issue(4'd0, 4'd1);
        check("rd0_issue_tag", 32'(IssueTag), 32'd1);
        check("rd0_occ", 32'(Occupancy), 32'd0);
        complete(4'd5, 32'h0000_0077);
        check("badcpl_err", 32'(CplErr), 32'd1);
        check("badcpl_no_retire", 32'(WbAddr), 32'd0);
        step();
        check("badcpl_no_retire2", 32'(WbAddr), 32'd0);
        check("badcpl_err_sticky", 32'(CplErr), 32'd1);
        check("badcpl_occ", 32'(Occupancy), 32'd0);

        // Tag wrap with pipelined issue/complete
        doReset();
        retired = 0;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                IssueValid = 1'b1;
                IssueRd    = 4'((i % 15) + 1);
                check("wrap_issue_tag", 32'(IssueTag), 32'((i + 1) % 16));
                exp_q.push_back({4'((i % 15) + 1), 4'((i + 1) % 16)});
            end
            if (i > 0) begin
                CplValid = 1'b1;
                CplTag   = 4'(i % 16);
                CplData  = 32'hC0DE_0000 | 32'(i % 16);
            end
            step();
            IssueValid = 1'b0;
            CplValid   = 1'b0;
            sbSample();
        end
        for (int k = 0; k < 4; k++) begin
            step();
            sbSample();
        end
        check("wrap_retired", 32'(retired), 32'd20);
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
        check("wrap_cpl_err", 32'(CplErr), 32'd0);
        check("wrap_occ", 32'(Occupancy), 32'd0);

        // Asynchronous reset mid-operation
        doReset();
        for (int i = 0; i < 5; i++) begin
            issue(4'(i + 1), 4'(i + 1));
        end
        complete(4'd1, 32'h0000_1234);
        complete(4'd9, 32'h0000_0000);
        check("mid_occ", 32'(Occupancy), 32'd4);
        check("mid_wb_addr", 32'(WbAddr), 32'd1);
        check("mid_cpl_err", 32'(CplErr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wb_addr", 32'(WbAddr), 32'd0);
        check("arst_wb_tag", 32'(WbTag), 32'd0);
        check("arst_rd_data", RdData, 32'd0);
        check("arst_occ", 32'(Occupancy), 32'd0);
        check("arst_cpl_err", 32'(CplErr), 32'd0);
        check("arst_issue_tag", 32'(IssueTag), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(4'd7, 4'd1);
        complete(4'd1, 32'h0000_BEEF);
        step();
        check("post_rst_wb_addr", 32'(WbAddr), 32'd7);
        check("post_rst_wb_tag", 32'(WbTag), 32'd1);
        check("post_rst_rd_data", RdData, 32'h0000_BEEF);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/wb_retire_queue.md
WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

Interface
REQ-001 SHALL have parameter embedded, default 1: regfile address width raddr_w = embedded ? 4 : 5.
REQ-002 SHALL have parameter wb_depth, default 16: in-flight slot count, power of two; tag_w = wb_depth > 1 ? clog2(wb_depth) : 1.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port IssueValid, input, 1: an instruction is issuing this cycle.
REQ-006 SHALL have port IssueRd, input, raddr_w: destination register of the issuing instruction.
REQ-007 SHALL have port IssueReady, output, 1: a slot is free; issue is accepted when IssueValid & IssueReady.
REQ-008 SHALL have port IssueTag, output, tag_w: tag assigned to the current issue (HorizonTag+1); matches the regfile's issued tag.
REQ-009 SHALL have port CplValid, input, 1: an execution unit is returning a result.
REQ-010 SHALL have port CplTag, input, tag_w: tag of the completing result.
REQ-011 SHALL have port CplData, input, 32: result value.
REQ-012 SHALL have port WbAddr, output, raddr_w: retiring register address, registered; 0 = no retire.
REQ-013 SHALL have port WbTag, output, tag_w: tag of the retiring slot, registered.
REQ-014 SHALL have port RdData, output, 32: retiring data, registered.
REQ-015 SHALL have port Occupancy, output, tag_w+1: allocated slot count.
REQ-016 SHALL have port CplErr, output, 1: sticky flag for an illegal completion.

Function
REQ-017 SHALL hold per-slot state (rd, data, alloc, done), indexed directly by tag; SHALL hold HeadTag and TailTag (reset 1), HorizonTag (reset 0) and a tag_w+1-bit count.
REQ-018 SHALL drive IssueReady = (count < wb_depth) combinationally; no same-cycle credit from a retire.
REQ-019 On an accepted issue with IssueRd != 0: write slot[TailTag] = {rd=IssueRd, alloc=1, done=0}; TailTag, HorizonTag += 1 mod wb_depth; count += 1.
REQ-020 On an accepted issue with IssueRd == 0: no allocation, no tag advance, IssueTag unchanged.
REQ-021 On CplValid with slot[CplTag] alloc=1 and done=0: write data and set done=1 at the next edge.
REQ-022 On CplValid to a slot with alloc=0 or done=1: ignore the result, leave the slot unchanged, set CplErr=1 until reset.
REQ-023 Retire: at each edge where slot[HeadTag] has alloc=1 and done=1, load WbAddr=rd, WbTag=HeadTag, RdData=data; clear alloc; HeadTag += 1; count -= 1.
REQ-024 At each edge with no retire, SHALL load WbAddr=0; WbTag and RdData SHALL hold their previous values.
REQ-025 Retire SHALL be strictly in tag order; a completed younger slot SHALL wait behind an incomplete head.
REQ-026 Latency: completion sampled at edge N -> earliest WbAddr valid after edge N+1; throughput is one retire per cycle.
REQ-027 Issue and retire in the same cycle: count is unchanged; both pointer updates apply.
REQ-028 Completion to HeadTag in the same cycle the head is examined: done is not visible until the next cycle, so there is no bypass.
REQ-029 Full (count == wb_depth): IssueReady=0, and IssueValid is ignored with no state change.
REQ-030 Tags and pointers SHALL wrap modulo wb_depth with no gap.
REQ-031 Occupancy SHALL equal count.

Reset
REQ-032 On rst_n low, asynchronously: all alloc/done=0, HeadTag=TailTag=1, HorizonTag=0, count=0, WbAddr=0, WbTag=0, RdData=0, CplErr=0.
REQ-033 Reset mid-operation SHALL discard all in-flight slots; the first issue after reset SHALL receive tag 1.

Verification
REQ-034 Reset, then issue rd=3 -> IssueTag=1; CplTag=1, CplData=0xDEADBEEF -> two edges later WbAddr=3, WbTag=1, RdData=0xDEADBEEF, and WbAddr=0 on the following cycle.
REQ-035 Issue rd=1,2,3 (tags 1,2,3), complete tags 3,2 then 1 -> retires of rd 1,2,3 on three consecutive cycles after tag 1 completes.
REQ-036 Issue 16 times with rd != 0 and no completion -> IssueReady=0, Occupancy=16; a 17th IssueValid is ignored; complete tag 1 -> IssueReady=1 after the retire.
REQ-037 Issue rd=0 -> IssueTag stays 1 and Occupancy stays 0; complete an unallocated tag 5 -> CplErr=1 and nothing retires.
REQ-038 Issue 20 times with completions (wrap) -> tags 1..15,0,1..4 in order; retired WbTag sequence is identical.
REQ-039 Assert rst_n low with 4 slots in flight -> all outputs 0 immediately; after release, a new issue gets IssueTag=1.
